change_dispenser: RTL and testbench

Change dispenser for the vending machine. It accepts a change amount from the vending-machine top and issues it as a sequence of physical coins to a coin hopper, using greedy decomposition over four denominations and a valid/ack handshake per coin. It is the payout end of the coin path: the keypad/money-calculation side accumulates coins in, and this block pays coins out. It also reports the undispensable residual and per-transaction coin count.

---
 rtl/change_dispenser.sv | 160 ++++++++++++++++
 tb/tb_change_dispenser.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount out as a sequence of coins over four denominations.
// Optional ack-timeout abort is built when CHANGE_DISP_TIMEOUT_EN is defined.
module change_dispenser #(
   parameter int               AMT_W          = 10,
   parameter logic [AMT_W-1:0] DENOM_3        = 10'd100,
   parameter logic [AMT_W-1:0] DENOM_2        = 10'd50,
   parameter logic [AMT_W-1:0] DENOM_1        = 10'd10,
   parameter logic [AMT_W-1:0] DENOM_0        = 10'd5,
   parameter int               TIMEOUT_CYCLES = 1000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [AMT_W-1:0] i_change,
   input  logic [3:0]       i_hopper_empty,
   input  logic             i_coin_ack,
   output logic             o_coin_valid,
   output logic [1:0]       o_coin_sel,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_short,
   output logic             o_fault,
   output logic [AMT_W-1:0] o_remaining,
   output logic [7:0]       o_coin_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      ISSUE,
      DONE
   } state_t;

   localparam logic [AMT_W-1:0] DENOM [4] = '{DENOM_0, DENOM_1, DENOM_2, DENOM_3};

   if (!((DENOM_3 > DENOM_2) && (DENOM_2 > DENOM_1) && (DENOM_1 > DENOM_0) && (DENOM_0 > 0))
       || (TIMEOUT_CYCLES < 1)) begin : gBadParams
      $error("change_dispenser: denominations must be strictly decreasing and nonzero");
   end

   state_t           state_q;
   logic [AMT_W-1:0] remaining_q;
   logic [1:0]       sel_q;
   logic             coinValid_q;
   logic             busy_q;
   logic             done_q;
   logic             short_q;
   logic [7:0]       coinCnt_q;

   logic             selFound_d;
   logic [1:0]       selIdx_d;
   logic [AMT_W-1:0] remaining_d;
   logic [7:0]       coinCnt_d;

`ifdef CHANGE_DISP_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmoCnt_q;
   logic             fault_q;
   assign o_fault = fault_q;
`else
   assign o_fault = 1'b0;
`endif

   // Ascending scan so the highest eligible denomination wins.
   always_comb begin
      selFound_d = 1'b0;
      selIdx_d   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (!i_hopper_empty[k] && (DENOM[k] <= remaining_q)) begin
            selFound_d = 1'b1;
            selIdx_d   = 2'(k);
         end
      end
   end

   assign remaining_d = remaining_q - DENOM[sel_q];
   assign coinCnt_d   = (coinCnt_q == 8'hFF) ? coinCnt_q : coinCnt_q + 8'd1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         sel_q       <= 2'd0;
         coinValid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         short_q     <= 1'b0;
         coinCnt_q   <= 8'd0;
`ifdef CHANGE_DISP_TIMEOUT_EN
         tmoCnt_q    <= '0;
         fault_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (i_start) begin
                  remaining_q <= i_change;
                  coinCnt_q   <= 8'd0;
                  short_q     <= 1'b0;
`ifdef CHANGE_DISP_TIMEOUT_EN
                  fault_q     <= 1'b0;
`endif
                  busy_q      <= 1'b1;
                  state_q     <= SELECT;
               end
            end
            SELECT: begin
               if (selFound_d) begin
                  sel_q       <= selIdx_d;
                  coinValid_q <= 1'b1;
`ifdef CHANGE_DISP_TIMEOUT_EN
                  tmoCnt_q    <= '0;
`endif
                  state_q     <= ISSUE;
               end else begin
                  short_q <= (remaining_q != '0);
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            ISSUE: begin
               if (i_coin_ack) begin
                  remaining_q <= remaining_d;
                  coinCnt_q   <= coinCnt_d;
                  coinValid_q <= 1'b0;
                  state_q     <= SELECT;
               end
`ifdef CHANGE_DISP_TIMEOUT_EN
               // Abort leaves remaining and count untouched so the residual is visible.
               else if (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES)) begin
                  coinValid_q <= 1'b0;
                  fault_q     <= 1'b1;
                  short_q     <= (remaining_q != '0);
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  tmoCnt_q <= tmoCnt_q + 1'b1;
               end
`endif
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_coin_valid = coinValid_q;
   assign o_coin_sel   = sel_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_short      = short_q;
   assign o_remaining  = remaining_q;
   assign o_coin_cnt   = coinCnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table plus scoreboard of coins and results.
// Define CHANGE_DISP_TIMEOUT_EN to also exercise the ack-timeout abort.
module tb_change_dispenser;

`ifdef CHANGE_DISP_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1000;
`endif

   logic       clk;
   logic       rst;
   logic       start;
   logic [9:0] change;
   logic [3:0] hopperEmpty;
   logic       coinAck;
   logic       coinValid;
   logic [1:0] coinSel;
   logic       busy;
   logic       done;
   logic       shortO;
   logic       fault;
   logic [9:0] remaining;
   logic [7:0] coinCnt;

   change_dispenser #(
      .AMT_W(10),
      .DENOM_3(10'd100),
      .DENOM_2(10'd50),
      .DENOM_1(10'd10),
      .DENOM_0(10'd5),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_start(start),
      .i_change(change),
      .i_hopper_empty(hopperEmpty),
      .i_coin_ack(coinAck),
      .o_coin_valid(coinValid),
      .o_coin_sel(coinSel),
      .o_busy(busy),
      .o_done(done),
      .o_short(shortO),
      .o_fault(fault),
      .o_remaining(remaining),
      .o_coin_cnt(coinCnt)
   );

   typedef struct {
      int cnt;
      int rem;
      int shrt;
      int flt;
      int cycles;
   } result_t;

   typedef struct {
      int         chg;
      logic [3:0] empty;
      int         delay;
      int         expCnt;
      int         expRem;
      int         expShort;
      int         expCycles;
   } vec_t;

   int      checks = 0;
   int      failures = 0;
   int      expSelQ[$];
   result_t expResQ[$];
   vec_t    vecs[$];
   int      ackDelay = 0;
   int      waitCnt = 0;
   int      cycleNo = 0;
   int      startCycle = 0;
   bit      doneSeen = 0;
   bit      monitorOn = 1;
   bit      prevValid = 0;
   bit      prevXfer = 0;
   int      prevSel = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycleNo++;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cycleNo);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycleNo);
      end
   endtask

   // Hopper model: ackDelay<0 ties ack high, otherwise acks after ackDelay waiting cycles.
   initial begin
      coinAck = 1'b0;
      forever begin
         @(negedge clk);
         if (ackDelay < 0) begin
            coinAck = 1'b1;
         end else if (coinValid && !coinAck) begin
            if (waitCnt >= ackDelay) begin
               coinAck = 1'b1;
               waitCnt = 0;
            end else begin
               waitCnt++;
            end
         end else begin
            coinAck = 1'b0;
            waitCnt = 0;
         end
      end
   end

   // Scoreboard consumer: coins at each transfer, results at each done pulse.
   initial begin
      result_t r;
      forever begin
         @(negedge clk);
         #1;
         if (monitorOn) begin
            if (coinValid && prevValid && !prevXfer)
               checkOutput("sel_stable", coinSel, prevSel);
            if (coinValid && coinAck) begin
               if (expSelQ.size() == 0) checkOutput("unexpected_coin_sel", coinSel, -1);
               else checkOutput("coin_sel", coinSel, expSelQ.pop_front());
            end
            if (done) begin
               doneSeen = 1;
               if (expResQ.size() == 0) begin
                  checkOutput("unexpected_done", done, 0);
               end else begin
                  r = expResQ.pop_front();
                  checkOutput("coin_cnt", coinCnt, r.cnt);
                  checkOutput("remaining", remaining, r.rem);
                  checkOutput("short", shortO, r.shrt);
                  checkOutput("fault", fault, r.flt);
                  checkOutput("busy_in_done", busy, 1);
                  if (r.cycles > 0) checkOutput("done_latency", cycleNo - startCycle + 1, r.cycles);
               end
            end
         end
         prevValid = coinValid;
         prevSel   = coinSel;
         prevXfer  = coinValid && coinAck;
      end
   end

   task automatic modelTxn(input int chg, input logic [3:0] empty, output int cnt, output int rem);
      int denom [4];
      bit found;
      denom = '{5, 10, 50, 100};
      rem = chg;
      cnt = 0;
      do begin
         found = 0;
         for (int k = 3; k >= 0; k--) begin
            if (!found && !empty[k] && denom[k] <= rem) begin
               found = 1;
               rem -= denom[k];
               cnt++;
               expSelQ.push_back(k);
            end
         end
      end while (found);
   endtask

   task automatic applyStimulus(input int chg, input logic [3:0] empty, input int delay);
      @(negedge clk);
      change      = 10'(chg);
      hopperEmpty = empty;
      ackDelay    = delay;
      doneSeen    = 0;
      start       = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      startCycle = cycleNo;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitDone(input int budget, input int expShort, input int expFault);
      int n = 0;
      while (!doneSeen && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      checkOutput("done_seen", doneSeen, 1);
      if (!doneSeen) begin
         expSelQ.delete();
         expResQ.delete();
         resetDut();
      end else begin
         checkOutput("coins_consumed", expSelQ.size(), 0);
         @(negedge clk);
         #2;
         checkOutput("busy_after_done", busy, 0);
         checkOutput("done_one_cycle", done, 0);
         checkOutput("short_held", shortO, expShort);
         checkOutput("fault_held", fault, expFault);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_valid"}, coinValid, 0);
      checkOutput({tag, "_sel"}, coinSel, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_short"}, shortO, 0);
      checkOutput({tag, "_fault"}, fault, 0);
      checkOutput({tag, "_remaining"}, remaining, 0);
      checkOutput({tag, "_cnt"}, coinCnt, 0);
   endtask

   initial begin
      int mc;
      int mr;
      int d;
      result_t r;
      vec_t v;
      rst         = 1'b1;
      start       = 1'b0;
      change      = '0;
      hopperEmpty = '0;

      // {change, empty mask, ack delay (-1 = tied high), cnt, remaining, short, done latency (0 = skip)}
      vecs.push_back('{185, 4'b0000, -1,  6,    0, 0, 14});
      vecs.push_back('{150, 4'b1000,  0,  3,    0, 0,  8});
      vecs.push_back('{ 58, 4'b0000,  0,  2,    3, 1,  6});
      vecs.push_back('{  0, 4'b0000,  0,  0,    0, 0,  2});
      vecs.push_back('{  3, 4'b0000,  0,  0,    3, 1,  2});
      vecs.push_back('{1023, 4'b1111, 0,  0, 1023, 1,  2});
      vecs.push_back('{ 95, 4'b0001,  1,  5,    5, 1,  0});
      vecs.push_back('{1023, 4'b0000, 0, 12,    3, 1, 26});
      vecs.push_back('{185, 4'b0110,  0, 18,    0, 0, 38});
      vecs.push_back('{  7, 4'b0000,  2,  1,    2, 1,  0});

      repeat (2) @(negedge clk);
      #1;
      checkReset("reset");
      rst = 1'b0;

      foreach (vecs[i]) begin
         v = vecs[i];
         modelTxn(v.chg, v.empty, mc, mr);
         r = '{v.expCnt, v.expRem, v.expShort, 0, v.expCycles};
         expResQ.push_back(r);
         applyStimulus(v.chg, v.empty, v.delay);
         waitDone(400, v.expShort, 0);
      end

      for (int i = 0; i < 4; i++) begin
         d = int'($urandom_range(0, 3));
         v.chg = int'($urandom_range(0, 1023));
         v.empty = 4'($urandom_range(0, 15));
         modelTxn(v.chg, v.empty, mc, mr);
         r = '{mc, mr, (mr != 0) ? 1 : 0, 0, (d == 0) ? 2 * mc + 2 : 0};
         expResQ.push_back(r);
         applyStimulus(v.chg, v.empty, d);
         waitDone(2000, r.shrt, 0);
      end

      // Slow hopper with a second start request while busy; it must be ignored.
      modelTxn(60, 4'b0000, mc, mr);
      expResQ.push_back('{2, 0, 0, 0, 0});
      applyStimulus(60, 4'b0000, 5);
      repeat (3) @(negedge clk);
      #2;
      checkOutput("busy_mid", busy, 1);
      @(negedge clk);
      change = 10'd999;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      change = 10'd60;
      waitDone(200, 0, 0);

      // Reset while a coin is presented and ack is high: the transfer must not land.
      monitorOn = 0;
      applyStimulus(100, 4'b0000, -1);
      for (int i = 0; i < 10 && !coinValid; i++) begin
         @(negedge clk);
         #2;
      end
      checkOutput("valid_before_reset", coinValid, 1);
      rst = 1'b1;
      @(negedge clk);
      #2;
      checkReset("issue_reset");
      rst = 1'b0;
      ackDelay = 0;
      @(negedge clk);
      monitorOn = 1;

`ifdef CHANGE_DISP_TIMEOUT_EN
      expResQ.push_back('{0, 50, 1, 1, 11});
      applyStimulus(50, 4'b0000, 100000);
      waitDone(100, 1, 1);
      ackDelay = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
